traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 143 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - traffic light sequence and dwell-time monitor
// Tracks RED->RED_YELLOW->GREEN->YELLOW->RED and flags illegal transitions and dwell violations.
module traffic_light_monitor #(
  parameter int T_RED    = 10,
  parameter int T_RY     = 3,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [2:0]  tl_i,
  output logic [2:0]  phase_o,
  output logic        err_seq_o,
  output logic        err_time_o,
  output logic [7:0]  err_cnt_o,
  output logic [15:0] cycle_cnt_o,
  output logic        sync_o
);

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] RY  = 3'b110;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;

  typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  tl_q;
  logic [15:0] dwell_q, dwell_d;
  logic        first_q, first_d;
  logic        err_seq_q, err_seq_d;
  logic        err_time_q, err_time_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] cycle_q, cycle_d;
  logic        change;
  logic [15:0] t_old;
  logic [2:0]  next_legal;

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      RED:     return RY;
      RY:      return GRN;
      GRN:     return YEL;
      YEL:     return RED;
      default: return OFF;
    endcase
  endfunction

  function automatic logic [15:0] dwell_limit(input logic [2:0] c);
    case (c)
      RED:     return 16'(T_RED);
      RY:      return 16'(T_RY);
      GRN:     return 16'(T_GREEN);
      YEL:     return 16'(T_YELLOW);
      default: return 16'd0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    first_d    = first_q;
    err_seq_d  = 1'b0;
    err_time_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    cycle_d    = cycle_q;
    change     = (tl_i != tl_q);
    t_old      = dwell_limit(tl_q);
    next_legal = succ(tl_q);

    if (change) begin
      dwell_d = 16'd1;
      first_d = 1'b0;
    end else if (dwell_q != 16'hFFFF) begin
      dwell_d = dwell_q + 16'd1;
    end

    if (!en_i) begin
      state_d = IDLE;
      if (change && tl_i != OFF) err_seq_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (tl_i == RED) begin
            state_d = TRACK;
            dwell_d = 16'd1;
            first_d = 1'b1;
          end
        end
        TRACK: begin
          if (change) begin
            // A phase that ran long was already reported by the overrun pulse.
            if (!first_q && dwell_q < t_old) err_time_d = 1'b1;
            if (tl_i == next_legal) begin
              if (tl_q == YEL) cycle_d = cycle_q + 16'd1;
            end else begin
              err_seq_d = 1'b1;
              state_d   = SYNC;
            end
          end else if (!first_q && dwell_d == t_old + 16'd1) begin
            err_time_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if ((err_seq_d || err_time_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tl_q       <= OFF;
      dwell_q    <= 16'd0;
      first_q    <= 1'b0;
      err_seq_q  <= 1'b0;
      err_time_q <= 1'b0;
      err_cnt_q  <= 8'd0;
      cycle_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      tl_q       <= tl_i;
      dwell_q    <= dwell_d;
      first_q    <= first_d;
      err_seq_q  <= err_seq_d;
      err_time_q <= err_time_d;
      err_cnt_q  <= err_cnt_d;
      cycle_q    <= cycle_d;
    end
  end

  assign phase_o     = tl_q;
  assign err_seq_o   = err_seq_q;
  assign err_time_o  = err_time_q;
  assign err_cnt_o   = err_cnt_q;
  assign cycle_cnt_o = cycle_q;
  assign sync_o      = (state_q == TRACK);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_traffic_light_monitor;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] RY  = 3'b110;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] BAD = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [2:0]  tl_i;
  logic [2:0]  phase_o;
  logic        err_seq_o;
  logic        err_time_o;
  logic [7:0]  err_cnt_o;
  logic [15:0] cycle_cnt_o;
  logic        sync_o;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  traffic_light_monitor #(
    .T_RED(4), .T_RY(2), .T_GREEN(4), .T_YELLOW(2)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .tl_i(tl_i),
    .phase_o(phase_o), .err_seq_o(err_seq_o), .err_time_o(err_time_o),
    .err_cnt_o(err_cnt_o), .cycle_cnt_o(cycle_cnt_o), .sync_o(sync_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [2:0] c, input logic e);
    @(negedge clk);
    tl_i = c;
    en_i = e;
    @(posedge clk);
    #1;
    if (err_seq_o || err_time_o) pulses++;
  endtask

  task automatic ticks(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) tick(c, 1'b1);
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; tl_i = OFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", 16'(phase_o), 16'(OFF));
    check("rst_sync", 16'(sync_o), 16'd0);
    check("rst_pulses", 16'({err_seq_o, err_time_o}), 16'd0);
    check("rst_err_cnt", 16'(err_cnt_o), 16'd0);
    check("rst_cycle_cnt", cycle_cnt_o, 16'd0);

    // Legal run: RED x6 then three full cycles
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    tick(RED, 1'b1);
    check("release_no_pulse", 16'({err_seq_o, err_time_o}), 16'd0);
    check("release_phase", 16'(phase_o), 16'(RED));
    check("release_sync", 16'(sync_o), 16'd0);
    tick(RED, 1'b1);
    check("sync_on_red", 16'(sync_o), 16'd1);
    ticks(RED, 4);
    for (int k = 0; k < 3; k++) begin
      ticks(RY, 2); ticks(GRN, 4); ticks(YEL, 2); ticks(RED, 4);
    end
    check("legal_pulses", 16'(pulses), 16'd0);
    check("legal_sync", 16'(sync_o), 16'd1);
    check("legal_cycle_cnt", cycle_cnt_o, 16'd3);
    check("legal_err_cnt", 16'(err_cnt_o), 16'd0);

    // Skip RED->GREEN
    tick(GRN, 1'b1);
    check("skip_seq", 16'(err_seq_o), 16'd1);
    check("skip_time", 16'(err_time_o), 16'd0);
    check("skip_sync", 16'(sync_o), 16'd0);
    check("skip_err_cnt", 16'(err_cnt_o), 16'd1);
    tick(GRN, 1'b1);
    check("skip_pulse_one_cycle", 16'(err_seq_o), 16'd0);
    tick(RED, 1'b1);
    check("resync_sync", 16'(sync_o), 16'd1);

    // Short GREEN, then overlong GREEN
    ticks(RED, 3); ticks(RY, 2); ticks(GRN, 3);
    tick(YEL, 1'b1);
    check("short_time", 16'(err_time_o), 16'd1);
    check("short_seq", 16'(err_seq_o), 16'd0);
    check("short_err_cnt", 16'(err_cnt_o), 16'd2);
    tick(YEL, 1'b1);
    ticks(RED, 4); ticks(RY, 2); ticks(GRN, 4);
    check("long_before", 16'(err_time_o), 16'd0);
    tick(GRN, 1'b1);
    check("long_overrun", 16'(err_time_o), 16'd1);
    check("long_err_cnt", 16'(err_cnt_o), 16'd3);
    tick(GRN, 1'b1);
    check("long_once", 16'(err_time_o), 16'd0);
    tick(YEL, 1'b1);
    check("long_change_time", 16'(err_time_o), 16'd0);
    check("long_change_seq", 16'(err_seq_o), 16'd0);
    check("long_err_cnt2", 16'(err_cnt_o), 16'd3);

    // Disable mid-GREEN
    tick(YEL, 1'b1);
    ticks(RED, 4); ticks(RY, 2); ticks(GRN, 2);
    check("dis_cycle_cnt", cycle_cnt_o, 16'd5);
    tick(OFF, 1'b0);
    check("dis_no_err", 16'({err_seq_o, err_time_o}), 16'd0);
    check("dis_sync", 16'(sync_o), 16'd0);
    check("dis_err_cnt", 16'(err_cnt_o), 16'd3);
    tick(OFF, 1'b0);
    tick(RED, 1'b0);
    check("idle_red_seq", 16'(err_seq_o), 16'd1);
    check("idle_red_err_cnt", 16'(err_cnt_o), 16'd4);
    tick(RED, 1'b0);
    check("idle_stable", 16'(err_seq_o), 16'd0);

    // Saturation: every change away from OFF while disabled is an error
    for (int i = 0; i < 300; i++) tick((i % 2 == 0) ? GRN : RED, 1'b0);
    check("sat_pulse", 16'(err_seq_o), 16'd1);
    check("sat_err_cnt", 16'(err_cnt_o), 16'd255);
    tick(BAD, 1'b0);
    check("illegal_change", 16'(err_seq_o), 16'd1);
    tick(BAD, 1'b0);
    check("illegal_stable", 16'(err_seq_o), 16'd0);
    check("sat_hold", 16'(err_cnt_o), 16'd255);

    // Reset mid-TRACK
    tick(RED, 1'b1);
    tick(RED, 1'b1);
    check("pre_rst_sync", 16'(sync_o), 16'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_phase", 16'(phase_o), 16'(OFF));
    check("mid_rst_sync", 16'(sync_o), 16'd0);
    check("mid_rst_err_cnt", 16'(err_cnt_o), 16'd0);
    check("mid_rst_cycle_cnt", cycle_cnt_o, 16'd0);
    check("mid_rst_pulses", 16'({err_seq_o, err_time_o}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    tick(RED, 1'b1);
    check("rel2_no_pulse", 16'({err_seq_o, err_time_o}), 16'd0);
    ticks(RED, 8); ticks(RY, 2); tick(GRN, 1'b1);
    check("rel2_first_red_unchecked", 16'(pulses), 16'd0);
    check("rel2_sync", 16'(sync_o), 16'd1);
    check("rel2_err_cnt", 16'(err_cnt_o), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
